// File: rtl/motor_pwm_sched.sv
// motor_pwm_sched: per-axis PWM generator with periodic back-EMF measure window and ADC handshake
module motor_pwm_sched #(
  parameter int PWIDTH = 16,
  parameter int AWIDTH = 10
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic [2:0]        Addr,
  input  logic [15:0]       DataWr,
  output logic [15:0]       DataRd,
  input  logic              En,
  input  logic              Rd,
  input  logic              Wr,
  output logic              PwmOut,
  output logic [1:0]        PwmCont,
  output logic              Active,
  output logic              AdcReq,
  input  logic              AdcAck,
  input  logic [AWIDTH-1:0] AdcData,
  output logic              IntStatus,
  input  logic              IntReset
);
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, SETTLE = 2'd2, SAMPLE = 2'd3;
  logic [1:0] state, stateNx, modeSh;
  logic [PWIDTH-1:0] period, duty, periodSh, dutySh, cnt, periodNx, dutyNx;
  logic [2:0] ctrl, ctrlNx;
  logic [15:0] measCfg;
  logic [7:0] periodCnt, settleCnt, pcInc;
  logic [AWIDTH-1:0] sample;
  logic wrEn, wrap, measDue, take, loadSh, pwmOut, intStatus;
  assign wrEn = En && Wr;
  assign periodNx = (wrEn && Addr == 3'd0) ? PWIDTH'(DataWr) : period;
  assign dutyNx = (wrEn && Addr == 3'd1) ? PWIDTH'(DataWr) : duty;
  assign ctrlNx = (wrEn && Addr == 3'd2) ? DataWr[2:0] : ctrl;
  assign wrap = cnt >= periodSh;
  assign pcInc = periodCnt + 8'd1;
  assign measDue = wrap && measCfg[7:0] != 8'd0 && pcInc >= measCfg[7:0];
  // Settle lasts max(settle,1) cycles: the counter is checked before it would hit 0.
  assign stateNx = !ctrlNx[2] ? IDLE :
                   state == IDLE   ? DRIVE :
                   state == DRIVE  ? (measDue ? SETTLE : DRIVE) :
                   state == SETTLE ? (settleCnt <= 8'd1 ? SAMPLE : SETTLE) :
                   (AdcAck ? DRIVE : SAMPLE);
  assign take = state == SAMPLE && stateNx == DRIVE;
  assign loadSh = state == IDLE || (state == DRIVE && wrap);
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
      period <= '0;
      duty <= '0;
      ctrl <= '0;
      measCfg <= '0;
      periodSh <= '0;
      dutySh <= '0;
      modeSh <= '0;
      cnt <= '0;
      periodCnt <= '0;
      settleCnt <= '0;
      pwmOut <= 1'b0;
      sample <= '0;
      intStatus <= 1'b0;
    end else begin
      state <= stateNx;
      period <= periodNx;
      duty <= dutyNx;
      ctrl <= ctrlNx;
      if (wrEn && Addr == 3'd3) measCfg <= DataWr;
      if (loadSh) begin
        periodSh <= periodNx;
        dutySh <= dutyNx;
        modeSh <= ctrlNx[1:0];
      end
      cnt <= (state == DRIVE && stateNx == DRIVE && !wrap) ? cnt + 1'b1 : '0;
      periodCnt <= (state != DRIVE || measDue) ? 8'd0 : wrap ? pcInc : periodCnt;
      settleCnt <= state == SETTLE ? settleCnt - 8'd1 : measCfg[15:8];
      pwmOut <= state == DRIVE && stateNx == DRIVE && cnt < dutySh;
      if (take) sample <= AdcData;
      intStatus <= take || (intStatus && !IntReset);
    end
  end
  assign PwmOut = pwmOut;
  assign PwmCont = state == IDLE ? 2'b00 : modeSh;
  assign Active = !state[1];
  assign AdcReq = state == SAMPLE;
  assign IntStatus = intStatus;
  assign DataRd = !(En && Rd) ? 16'd0 :
                  Addr == 3'd0 ? 16'(period) :
                  Addr == 3'd1 ? 16'(duty) :
                  Addr == 3'd2 ? {13'd0, ctrl} :
                  Addr == 3'd3 ? measCfg :
                  Addr == 3'd4 ? 16'(sample) :
                  Addr == 3'd5 ? {14'd0, state[1], intStatus} : 16'd0;
endmodule
